// File: rtl/cpu_pkg.sv
// Shared types and defaults for the recognition CPU pipeline stages.
package cpu_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  // Encoding of addi x0,x0,0; ID substitutes it when a slot is flushed.
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Control, instruction-memory and ID-register signals of the fetch stage.
interface if_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    input  stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/if_skid_reg.sv
// {valid, instr, pc} holding register with Tick-gated load and clear.
module if_skid_reg
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            tick,
  input  logic            load,
  input  logic            clear,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  output logic            q_valid,
  output logic [XLEN-1:0] q_instr,
  output logic [XLEN-1:0] q_pc
);

  // Clear only drops valid; the payload is left as-is since nobody reads it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q_valid <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (tick) begin
      if (clear) begin
        q_valid <= 1'b0;
      end else if (load) begin
        q_valid <= d_valid;
        q_instr <= d_instr;
        q_pc    <= d_pc;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and
// feeds a registered {instr, pc, valid} to the ID register.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              PC_STEP  = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Tick,
  if_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q;
  logic            pc_load, req_load;
  logic            out_load, out_clear, out_from_skid;
  logic            skid_load, skid_clear;

  logic            out_valid_q, skid_valid_q;
  logic [XLEN-1:0] out_instr_q, out_pc_q, skid_instr_q, skid_pc_q;
  logic            out_d_valid;
  logic [XLEN-1:0] out_d_instr, out_d_pc;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     state_q <= FETCH;
    else if (Tick) state_q <= state_d;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (Tick) begin
      if (pc_load)  pc_q     <= pc_d;
      if (req_load) req_pc_q <= pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (!bus.redirect && bus.imem_ready) state_d = WAIT;
      WAIT: begin
        if (bus.redirect)         state_d = bus.imem_rvalid ? FETCH : DROP;
        else if (bus.imem_rvalid) state_d = (!bus.stall || !out_valid_q) ? FETCH : HOLD;
      end
      HOLD:    if (bus.redirect || !bus.stall) state_d = FETCH;
      DROP:    if (bus.imem_rvalid) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Redirect flushes the output and restarts the PC from every state.
  always_comb begin
    bus.imem_req  = (state_q == FETCH);
    bus.imem_addr = bus.imem_req ? pc_q : '0;
    pc_load       = 1'b0;
    pc_d          = pc_q;
    req_load      = 1'b0;
    out_load      = 1'b0;
    out_clear     = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (bus.redirect) begin
      pc_load    = 1'b1;
      pc_d       = bus.redirect_pc;
      out_clear  = 1'b1;
      skid_clear = (state_q == HOLD);
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ready) begin
            req_load = 1'b1;
            pc_load  = 1'b1;
            pc_d     = pc_q + XLEN'(PC_STEP);
          end
          out_clear = !bus.stall;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (!bus.stall || !out_valid_q) out_load  = 1'b1;
            else                            skid_load = 1'b1;
          end else begin
            out_clear = !bus.stall;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            out_load      = 1'b1;
            out_from_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        DROP:    out_clear = !bus.stall;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_d_valid = out_from_skid ? skid_valid_q : 1'b1;
    out_d_instr = out_from_skid ? skid_instr_q : bus.imem_rdata;
    out_d_pc    = out_from_skid ? skid_pc_q    : req_pc_q;
  end

  if_skid_reg #(.XLEN(XLEN)) u_out_reg (
    .Clock   (Clock),
    .Reset   (Reset),
    .tick    (Tick),
    .load    (out_load),
    .clear   (out_clear),
    .d_valid (out_d_valid),
    .d_instr (out_d_instr),
    .d_pc    (out_d_pc),
    .q_valid (out_valid_q),
    .q_instr (out_instr_q),
    .q_pc    (out_pc_q)
  );

  if_skid_reg #(.XLEN(XLEN)) u_skid_reg (
    .Clock   (Clock),
    .Reset   (Reset),
    .tick    (Tick),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_valid (1'b1),
    .d_instr (bus.imem_rdata),
    .d_pc    (req_pc_q),
    .q_valid (skid_valid_q),
    .q_instr (skid_instr_q),
    .q_pc    (skid_pc_q)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the ID instruction register of the recognition CPU.
- Owns the PC and issues one instruction-memory read at a time.
- Presents a registered {instr, pc, valid} triple to the ID register and honours stall from the hazard logic and redirect from branch/jump resolution.
- All state advances only on Tick, matching the global Logisim-style clock-enable scheme.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Tick  in  1  global clock-enable; no state changes when 0.
- stall  in  1  ID stage cannot accept; hold output.
- redirect  in  1  taken branch/jump; restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address.
- imem_req  out  1  read request valid.
- imem_addr  out  XLEN  read address (current PC).
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  instruction word.
- out_valid  out  1  out_instr/out_pc valid for ID register.
- out_instr  out  XLEN  fetched instruction.
- out_pc  out  XLEN  PC of out_instr.

Behaviour:
- Reset is asynchronous, active-high; clock is Clock.
- Reset values: pc=RESET_PC, state=FETCH, out_valid=0, out_instr=0, out_pc=0.
- imem_req is combinational from state: 1 only in FETCH. imem_addr=pc whenever imem_req=1, else 0.
- Updates below occur on a rising Clock edge with Tick=1. With Tick=0, all registers hold.
- FETCH:
  - imem_req=1.
  - If imem_ready=1 and no redirect: latch req_pc=pc, pc<=pc+PC_STEP, go to WAIT.
  - If redirect=1: pc<=redirect_pc, stay in FETCH, nothing issued (redirect wins over ready).
- WAIT (one request outstanding):
  - redirect=1 with rvalid=0: pc<=redirect_pc, go to DROP.
  - redirect=1 with rvalid=1: response discarded, out_valid<=0, pc<=redirect_pc, go to FETCH.
  - rvalid=1, no redirect, and (stall=0 or out_valid=0): out_instr<=rdata, out_pc<=req_pc, out_valid<=1, go to FETCH.
  - rvalid=1, no redirect, stall=1, out_valid=1: capture into a one-entry skid register, go to HOLD.
- HOLD:
  - imem_req=0.
  - When stall falls: skid moves to outputs, go to FETCH.
  - redirect clears the skid, sets out_valid<=0, loads pc, goes to FETCH.
- DROP:
  - Wait for imem_rvalid, discard the data, go to FETCH.
  - A further redirect in DROP only reloads pc.
- Output register, in any state, no redirect:
  - stall=0 and no new data: out_valid<=0 (bubble).
  - stall=1: out_* hold.
  - Redirect forces out_valid<=0 next edge regardless of stall (flush beats stall).
- PC arithmetic is modulo 2^XLEN; wraps from all-ones-minus-3 to 0 without a flag.
- Sequential throughput: one instruction per two Ticks when memory latency is 1. Latency from accepted request to out_valid is rvalid cycle + 1.
- Reset mid-WAIT: all state is cleared immediately. A stale rvalid arriving after reset release while in FETCH is ignored (rvalid is only sampled in WAIT/DROP).

Decomposition:
- Shared package cpu_pkg:
  - state enum FETCH/WAIT/HOLD/DROP (2-bit);
  - XLEN and RESET_PC defaults;
  - NOP instruction constant used by ID on flush.
- One sub-module, if_skid_reg: XLEN+XLEN+1-bit register with load/clear/Tick, used for both the output register and the skid entry.

Test Plan:
- Reset, ready=1, 1-cycle memory returning addr+0x100 -> out_pc sequence 0,4,8 with out_instr 0x100,0x104,0x108, out_valid pulses every 2nd Tick.
- stall=1 for 5 Ticks while the second response arrives -> out_instr holds 0x100, HOLD entered, then 0x104 appears on the first Tick after stall=0 with no loss or duplicate.
- redirect to 0x40 while in WAIT, rvalid 2 cycles later -> response discarded, next imem_addr=0x40, out_valid=0 until the 0x40 instruction returns.
- redirect and rvalid in the same cycle, with stall=1 -> out_valid=0 next edge, next request at redirect_pc.
- Tick=0 for 10 cycles mid-WAIT with rvalid pulsing -> no state, PC or output change; capture occurs only on a Tick=1 edge.
- pc=32'hFFFF_FFFC fetch -> next imem_addr=0. Assert Reset mid-WAIT -> out_valid=0 and pc=RESET_PC immediately, and a later stray rvalid is ignored.
